// File: rtl/upsample_pkg.sv
// Shared CNN pixel-path constants (also used by the 4:1 downsampler) and upsampler types.
package upsample_pkg;

  localparam int IMG_W     = 112;
  localparam int DS_FACTOR = 4;
  localparam int DS_SHIFT  = 2;
  localparam int FEAT_W    = IMG_W / DS_FACTOR;
  localparam int CNT_W     = 7;
  localparam int IN_CNT_W  = 5;
  localparam int REP_W     = 2;

  localparam logic [IN_CNT_W-1:0] FEAT_LAST = IN_CNT_W'(FEAT_W - 1);
  localparam logic [CNT_W-1:0]    IMG_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [REP_W-1:0]    REP_LAST  = REP_W'(DS_FACTOR - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } up_state_e;

  // Output column to line-buffer entry: every DS_FACTOR columns share one input pixel.
  function automatic logic [IN_CNT_W-1:0] lbuf_idx(input logic [CNT_W-1:0] col);
    return col[CNT_W-1:DS_SHIFT];
  endfunction

endpackage

// File: rtl/upsample_if.sv
// Pixel stream bundle: 28x28 ready/valid input side and 112x112 raster output side.
interface upsample_if;
  import upsample_pkg::*;

  logic             bin_data;
  logic             bin_data_vld;
  logic             bin_data_rdy;
  logic             up_data;
  logic             up_data_vld;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             frame_last;

  modport slave (
    input  bin_data,
    input  bin_data_vld,
    output bin_data_rdy,
    output up_data,
    output up_data_vld,
    output col_cnt,
    output row_cnt,
    output frame_last
  );

  modport master (
    output bin_data,
    output bin_data_vld,
    input  bin_data_rdy,
    input  up_data,
    input  up_data_vld,
    input  col_cnt,
    input  row_cnt,
    input  frame_last
  );

endinterface

// File: rtl/upsample_lbuf.sv
// One-row line buffer: registered single-bit write port, combinational read port.
module upsample_lbuf
  import upsample_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IN_CNT_W-1:0] in_col,
  input  logic                bin_data,
  input  logic [IN_CNT_W-1:0] index,
  output logic                rd_data
);

  logic [FEAT_W-1:0] lbuf_r;

  // Line buffer storage, written one pixel per accepted input beat
  always_ff @(posedge clk) begin
    if (rst) begin
      lbuf_r <= {FEAT_W{1'b0}};
    end else if (we) begin
      lbuf_r[in_col] <= bin_data;
    end else begin
      lbuf_r <= lbuf_r;
    end
  end

  assign rd_data = lbuf_r[index];

endmodule

// File: rtl/upsample.sv
// Nearest-neighbour 4x binary upsampler: loads one 28-pixel row, then replays it as
// four 112-pixel output rows before accepting the next input row.
module upsample
  import upsample_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  upsample_if.slave up_if
);

  up_state_e           state_r, state_nxt_s;
  logic [IN_CNT_W-1:0] in_col_r, in_col_nxt_s;
  logic [REP_W-1:0]    rep_r, rep_nxt_s;
  logic [CNT_W-1:0]    out_col_r, out_col_nxt_s;
  logic [CNT_W-1:0]    out_row_r, out_row_nxt_s;
  logic [CNT_W-1:0]    col_cnt_r, col_cnt_nxt_s;
  logic [CNT_W-1:0]    row_cnt_r, row_cnt_nxt_s;
  logic                up_data_r, up_data_nxt_s;
  logic                up_vld_r, up_vld_nxt_s;
  logic                frame_last_r, frame_last_nxt_s;
  logic                rdy_s;
  logic                accept_s;
  logic                lbuf_rd_s;
  logic [IN_CNT_W-1:0] lbuf_idx_s;

  assign lbuf_idx_s = lbuf_idx(out_col_r);

  upsample_lbuf u_lbuf (
    .clk      (clk),
    .rst      (rst),
    .we       (accept_s),
    .in_col   (in_col_r),
    .bin_data (up_if.bin_data),
    .index    (lbuf_idx_s),
    .rd_data  (lbuf_rd_s)
  );

  // Next-state, counter advance and next output pixel
  always_comb begin
    state_nxt_s      = state_r;
    in_col_nxt_s     = in_col_r;
    rep_nxt_s        = rep_r;
    out_col_nxt_s    = out_col_r;
    out_row_nxt_s    = out_row_r;
    col_cnt_nxt_s    = col_cnt_r;
    row_cnt_nxt_s    = row_cnt_r;
    up_data_nxt_s    = 1'b0;
    up_vld_nxt_s     = 1'b0;
    frame_last_nxt_s = 1'b0;
    rdy_s            = 1'b0;
    accept_s         = 1'b0;

    case (state_r)
      ST_LOAD: begin
        rdy_s    = 1'b1;
        accept_s = up_if.bin_data_vld;
        if (accept_s) begin
          if (in_col_r == FEAT_LAST) begin
            in_col_nxt_s = {IN_CNT_W{1'b0}};
            state_nxt_s  = ST_EMIT;
          end else begin
            in_col_nxt_s = in_col_r + 5'd1;
          end
        end else begin
          in_col_nxt_s = in_col_r;
        end
      end

      ST_EMIT: begin
        up_data_nxt_s    = lbuf_rd_s;
        up_vld_nxt_s     = 1'b1;
        col_cnt_nxt_s    = out_col_r;
        row_cnt_nxt_s    = out_row_r;
        frame_last_nxt_s = (out_row_r == IMG_LAST) && (out_col_r == IMG_LAST);
        if (out_col_r == IMG_LAST) begin
          out_col_nxt_s = {CNT_W{1'b0}};
          rep_nxt_s     = rep_r + 2'd1;
          out_row_nxt_s = (out_row_r == IMG_LAST) ? {CNT_W{1'b0}} : out_row_r + 7'd1;
          // The last replica of this row hands back to LOAD on the same edge
          if (rep_r == REP_LAST) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_EMIT;
          end
        end else begin
          out_col_nxt_s = out_col_r + 7'd1;
        end
      end

      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LOAD;
      in_col_r     <= {IN_CNT_W{1'b0}};
      rep_r        <= {REP_W{1'b0}};
      out_col_r    <= {CNT_W{1'b0}};
      out_row_r    <= {CNT_W{1'b0}};
      col_cnt_r    <= {CNT_W{1'b0}};
      row_cnt_r    <= {CNT_W{1'b0}};
      up_data_r    <= 1'b0;
      up_vld_r     <= 1'b0;
      frame_last_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      in_col_r     <= in_col_nxt_s;
      rep_r        <= rep_nxt_s;
      out_col_r    <= out_col_nxt_s;
      out_row_r    <= out_row_nxt_s;
      col_cnt_r    <= col_cnt_nxt_s;
      row_cnt_r    <= row_cnt_nxt_s;
      up_data_r    <= up_data_nxt_s;
      up_vld_r     <= up_vld_nxt_s;
      frame_last_r <= frame_last_nxt_s;
    end
  end

  assign up_if.bin_data_rdy = rdy_s;
  assign up_if.up_data      = up_data_r;
  assign up_if.up_data_vld  = up_vld_r;
  assign up_if.col_cnt      = col_cnt_r;
  assign up_if.row_cnt      = row_cnt_r;
  assign up_if.frame_last   = frame_last_r;

endmodule

// File: tb/tb_upsample.sv
// Directed bench for upsample: full frames checked pixel-by-pixel against the source image,
// plus handshake, reset-in-flight and 4:1 round-trip checks.
module tb_upsample;
  import upsample_pkg::*;

  logic clk = 1'b0;
  logic rst;

  upsample_if u_if ();

  upsample u_dut (
    .clk   (clk),
    .rst   (rst),
    .up_if (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit in_img  [28][28];
  bit cap     [112][112];
  bit cap_ref [112][112];
  bit mon_en = 1'b0;
  bit toggle_v = 1'b0;
  int frames_done = 0;

  int er, ec, run_len, acc_frame, acc_cyc, cyc, npix;
  int e_pix, e_pos, e_last, e_rdy, e_run, e_lat, e_idle;
  int f_pix, f_pos, f_last, f_rdy, f_run, f_lat, f_idle, f_npix, f_acc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: handshake sampled at the edge, outputs 1 time unit after it
  always @(posedge clk) begin
    bit acc_now;
    bit rst_now;
    bit exp_bit;
    acc_now = mon_en && (u_if.bin_data_vld === 1'b1) && (u_if.bin_data_rdy === 1'b1) && (rst === 1'b0);
    rst_now = (rst === 1'b1);
    #1;
    cyc++;
    if (!mon_en || rst_now) begin
      er = 0; ec = 0; run_len = 0; acc_frame = 0; npix = 0;
      e_pix = 0; e_pos = 0; e_last = 0; e_rdy = 0; e_run = 0; e_lat = 0; e_idle = 0;
    end else begin
      if (acc_now) begin
        if (acc_frame % 28 == 27) acc_cyc = cyc;
        acc_frame++;
      end
      if (u_if.up_data_vld === 1'b1) begin
        exp_bit = in_img[er/4][ec/4];
        if (u_if.up_data !== exp_bit) e_pix++;
        if (u_if.col_cnt !== 7'(ec) || u_if.row_cnt !== 7'(er)) e_pos++;
        if (u_if.frame_last !== ((er == 111) && (ec == 111))) e_last++;
        if (u_if.bin_data_rdy !== ((ec == 111) && (er % 4 == 3))) e_rdy++;
        if (ec == 0 && er % 4 == 0 && (cyc - acc_cyc) != 1) e_lat++;
        run_len++;
        if (ec == 111 && er % 4 == 3 && run_len != 448) e_run++;
        cap[er][ec] = u_if.up_data;
        npix++;
        if (ec == 111) begin
          ec = 0;
          if (er == 111) begin
            er = 0;
            f_pix = e_pix; f_pos = e_pos; f_last = e_last; f_rdy = e_rdy;
            f_run = e_run; f_lat = e_lat; f_idle = e_idle; f_npix = npix; f_acc = acc_frame;
            e_pix = 0; e_pos = 0; e_last = 0; e_rdy = 0; e_run = 0; e_lat = 0; e_idle = 0;
            npix = 0; acc_frame = 0;
            frames_done++;
          end else begin
            er++;
          end
        end else begin
          ec++;
        end
      end else begin
        run_len = 0;
        if (u_if.up_data !== 1'b0 || u_if.frame_last !== 1'b0) e_idle++;
      end
    end
  end

  task automatic drive_idle(input bit noise);
    toggle_v = ~toggle_v;
    u_if.bin_data_vld = noise && (u_if.bin_data_rdy !== 1'b1);
    u_if.bin_data     = noise ? toggle_v : 1'b0;
  endtask

  task automatic send_rows(input int nrows, input int gap_pct, input bit noise);
    int idx = 0;
    int guard = 0;
    while (idx < nrows * 28 && guard < 30000) begin
      @(negedge clk);
      guard++;
      if (u_if.bin_data_rdy === 1'b1) begin
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          u_if.bin_data_vld = 1'b0;
          u_if.bin_data     = 1'($urandom);
        end else begin
          u_if.bin_data_vld = 1'b1;
          u_if.bin_data     = in_img[idx/28][idx%28];
          idx++;
        end
      end else begin
        drive_idle(noise);
      end
    end
    check_eq("beats_sent", idx, nrows * 28);
  endtask

  task automatic wait_frames(input int target, input bit noise);
    int g = 0;
    while (frames_done < target && g < 20000) begin
      @(negedge clk);
      drive_idle(noise);
      g++;
    end
    check_eq("frame_done", frames_done, target);
  endtask

  task automatic report_frame(input string tag);
    int rt = 0;
    check_eq({tag, "_pix"},  f_pix,  0);
    check_eq({tag, "_pos"},  f_pos,  0);
    check_eq({tag, "_last"}, f_last, 0);
    check_eq({tag, "_rdy"},  f_rdy,  0);
    check_eq({tag, "_run"},  f_run,  0);
    check_eq({tag, "_lat"},  f_lat,  0);
    check_eq({tag, "_idle"}, f_idle, 0);
    check_eq({tag, "_npix"}, f_npix, 12544);
    check_eq({tag, "_acc"},  f_acc,  784);
    // 4:1 majority downsample of the captured frame must reproduce the source
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        int s = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            s += int'(cap[4*r+i][4*c+j]);
        if ((s >= 8) != in_img[r][c]) rt++;
      end
    end
    check_eq({tag, "_roundtrip"}, rt, 0);
  endtask

  function automatic int count_ones();
    int n = 0;
    for (int r = 0; r < 112; r++)
      for (int c = 0; c < 112; c++)
        n += int'(cap[r][c]);
    return n;
  endfunction

  initial begin
    int found;
    int g;
    int diff;
    rst = 1'b1;
    u_if.bin_data_vld = 1'b0;
    u_if.bin_data     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy",   int'(u_if.bin_data_rdy), 1);
    check_eq("rst_vld",   int'(u_if.up_data_vld),  0);
    check_eq("rst_data",  int'(u_if.up_data),      0);
    check_eq("rst_col",   int'(u_if.col_cnt),      0);
    check_eq("rst_row",   int'(u_if.row_cnt),      0);
    check_eq("rst_last",  int'(u_if.frame_last),   0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Frame 1: all ones
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) in_img[r][c] = 1'b1;
    send_rows(28, 0, 1'b0);
    wait_frames(1, 1'b0);
    report_frame("ones");
    check_eq("ones_count", count_ones(), 12544);

    // Frame 2: single pixel at (5,9), vld/data toggling during every EMIT
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) in_img[r][c] = 1'b0;
    in_img[5][9] = 1'b1;
    send_rows(28, 0, 1'b1);
    wait_frames(2, 1'b1);
    report_frame("single");
    check_eq("single_count", count_ones(), 16);
    check_eq("single_20_36", int'(cap[20][36]), 1);
    check_eq("single_23_39", int'(cap[23][39]), 1);
    check_eq("single_19_36", int'(cap[19][36]), 0);
    check_eq("single_20_40", int'(cap[20][40]), 0);
    check_eq("single_24_39", int'(cap[24][39]), 0);

    // Reset at output pixel 200 of input row 3's burst, i.e. (row 13, col 88)
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) in_img[r][c] = 1'($urandom);
    send_rows(4, 0, 1'b0);
    found = 0;
    g = 0;
    while (found == 0 && g < 3000) begin
      @(negedge clk);
      g++;
      if (u_if.up_data_vld === 1'b1 && u_if.row_cnt == 7'd13 && u_if.col_cnt == 7'd88) found = 1;
      else drive_idle(1'b0);
    end
    check_eq("rst_point_seen", found, 1);
    rst = 1'b1;
    u_if.bin_data_vld = 1'b0;
    @(negedge clk);
    check_eq("midrst_vld",  int'(u_if.up_data_vld),  0);
    check_eq("midrst_rdy",  int'(u_if.bin_data_rdy), 1);
    check_eq("midrst_data", int'(u_if.up_data),      0);
    check_eq("midrst_col",  int'(u_if.col_cnt),      0);
    check_eq("midrst_row",  int'(u_if.row_cnt),      0);
    rst = 1'b0;

    // Frame 3: fresh random frame with ~50% input gaps
    send_rows(28, 50, 1'b0);
    wait_frames(3, 1'b0);
    report_frame("gaps");
    for (int r = 0; r < 112; r++) for (int c = 0; c < 112; c++) cap_ref[r][c] = cap[r][c];

    // Frame 4: same pattern without gaps must match frame 3 exactly
    send_rows(28, 0, 1'b0);
    wait_frames(4, 1'b0);
    report_frame("nogaps");
    diff = 0;
    for (int r = 0; r < 112; r++)
      for (int c = 0; c < 112; c++)
        if (cap[r][c] != cap_ref[r][c]) diff++;
    check_eq("gap_vs_nogap", diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/upsample.md
# upsample

Nearest-neighbour binary upsampler: accepts a 28×28 one-bit-per-pixel stream and emits a 112×112 stream in raster order, each input pixel replicated into a 4×4 block. It is the inverse of the 4:1 binary downsampler in the CNN pixel path, placed where a low-resolution feature or mask map must be re-aligned to the full 112×112 binarised image. The 16:1 rate expansion is absorbed by a single line buffer plus a ready/valid input handshake.

## Interface
- IN_W, 28, input pixels per row and rows per frame
- SCALE, 4, replication factor per axis (power of two)
- OUT_W, IN_W*SCALE = 112, output pixels per row and rows per frame

- clk  input  1  clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- bin_data  input  1  input pixel
- bin_data_vld  input  1  input pixel valid
- bin_data_rdy  output  1  block can accept; beat transfers when vld && rdy
- up_data  output  1  output pixel
- up_data_vld  output  1  output pixel valid; no output backpressure
- col_cnt  output  7  column of the pixel currently on up_data (0..111)
- row_cnt  output  7  row of the pixel currently on up_data (0..111)
- frame_last  output  1  high with pixel (111,111) only

## Operation
- State machine: LOAD, EMIT.
- LOAD: bin_data_rdy = 1; each accepted beat writes lbuf[in_col] (28-bit register), in_col increments 0..27. On accept with in_col = 27: in_col→0, state→EMIT.
- EMIT: bin_data_rdy = 0; emits one output pixel per cycle, 4 output rows × 112 columns = 448 cycles; pixel at (r, c) = lbuf[c >> 2]. out_col wraps 111→0 and advances rep 0..3; after rep 3 / out_col 111: state→LOAD, out_row advances by 1.
- out_row wraps 111→0 after last pixel of the frame; frame_last asserted with that pixel. Next frame starts in LOAD without any idle gap.
- bin_data/bin_data_vld ignored whenever bin_data_rdy = 0; no beat is lost or double-counted.
- Gaps in bin_data_vld during LOAD just stall in_col; lbuf contents are retained.
- Widths: in_col 5 bits, rep 2 bits, out_col/out_row 7 bits; lbuf index = out_col[6:2].

## Timing
- Reset values: state LOAD, bin_data_rdy 1 (combinational from state), up_data 0, up_data_vld 0, col_cnt 0, row_cnt 0, frame_last 0, all internal counters 0, lbuf 0.
- up_data, up_data_vld, col_cnt, row_cnt, frame_last are registered.
- Edge E0 accepts the 28th beat of a row, and the state becomes EMIT. Edge E1 registers output pixel 0, so up_data_vld is high in the cycle after E1. Output then runs for 448 consecutive valid cycles.
- State returns to LOAD at the edge registering pixel 447. bin_data_rdy is high in the same cycle pixel 447 is visible.
- Outside valid cycles up_data = 0, up_data_vld = 0, frame_last = 0. col_cnt/row_cnt hold their last values.
- Minimum period per input row: 28 + 448 = 476 cycles. Minimum frame: 28 × 476 = 13328 cycles.
- rst asserted at any point, including mid-EMIT: on the next edge all state returns to reset values. The partial frame is discarded, and the next accepted beat is treated as pixel (0,0).

## Structure
- Shared CNN package: IMG_W = 112, DS_FACTOR = 4, derived FEAT_W = 28, and the counter width constant (7). The downsampler uses the same constants.
- One sub-module is natural: upsample_lbuf. It holds the 28-bit line buffer with a write port (in_col, bin_data, we) and a read port (index). The FSM and counters stay in the top module.

## Test plan
- All-ones 28×28 frame, vld held high → 12544 output pixels all 1; frame_last high with the pixel at col_cnt = 111, row_cnt = 111.
- Single 1 at input (5,9) → exactly the output block rows 20..23, cols 36..39 is 1 (16 pixels); every other pixel is 0.
- Random vld gaps (~50% duty) during LOAD → output identical to the gap-free run; exactly 28 beats are accepted per row.
- bin_data_vld = 1 with bin_data toggling throughout EMIT → no beats are accepted and the output is unaffected; rdy rises in the cycle pixel 447 is visible.
- rst pulsed at output pixel 200 of row 3 → next cycle up_data_vld = 0 and rdy = 1; a fresh frame then starts at (0,0) and produces correct output.
- Round-trip: random 28×28 pattern → upsample → downsample → the downsampler's output equals the original 784 pixels.
